// File: rtl/fram_spi_pkg.sv
// Shared FRAM SPI definitions: opcodes, frame widths and target FSM encoding.
// Used by the target, the master and their benches.
package fram_spi_pkg;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 16;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_RDATA,
        S_WDATA,
        S_STATUS,
        S_IGNORE
    } fram_state_e;

    // MB85RS64V status register: only WEL (bit 1) is modelled.
    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer for one asynchronous SPI pin, with edge pulses taken from a third stage.
// All stages clear to 0 so reset never manufactures a CS falling edge.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= 3'b000;
        end else begin
            sr <= {sr[1:0], pin};
        end
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/fram_spi_target.sv
// SPI mode-0 target emulating the MB85RS64V command subset over a small byte array.
// SPI pins are oversampled by clk; all protocol state lives in the clk domain.
module fram_spi_target
    import fram_spi_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wel,
    output logic              cs_active,
    input  logic [ADDR_W-1:0] bd_addr,
    output logic [7:0]        bd_data,
    output fram_state_e       state_dbg
);

    // Handshake: none. SPI is a free-running serial link; the master owns SCK and CS
    // and this target only reacts to synchronized edges, one clk pulse per pin edge.

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_hi, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_pin_sync u_sync_sck  (.clk(clk), .rst(rst), .pin(spi_clk),  .level(sck_lvl), .rise(sck_rise),  .fall(sck_fall));
    spi_pin_sync u_sync_cs   (.clk(clk), .rst(rst), .pin(spi_cs_n), .level(cs_hi),   .rise(cs_rise),   .fall(cs_fall));
    spi_pin_sync u_sync_mosi (.clk(clk), .rst(rst), .pin(spi_mosi), .level(mosi_s),  .rise(mosi_rise), .fall(mosi_fall));

    logic [7:0]        mem [MEM_BYTES];
    fram_state_e       state, state_n;
    logic [4:0]        bit_cnt, bit_cnt_n;
    logic [14:0]       shift_in, shift_n;
    logic [15:0]       sin;
    logic [ADDR_W-1:0] ptr, ptr_n, rd_addr;
    logic              wel_n, wr_cmd, wr_cmd_n;
    logic [7:0]        tx, tx_n, ld_byte;
    logic              miso_n, oe_n, ld, mem_we, byte_done, armed;
    logic              unused_sync;

    assign sin         = {shift_in, mosi_s};
    assign bd_data     = mem[bd_addr];
    assign cs_active   = armed & ~cs_hi;
    assign state_dbg   = state;
    assign unused_sync = ^{sck_lvl, cs_rise, mosi_rise, mosi_fall, sin[15]};

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_in;
        ptr_n     = ptr;
        wel_n     = wel;
        wr_cmd_n  = wr_cmd;
        tx_n      = tx;
        miso_n    = spi_miso;
        oe_n      = spi_miso_oe;
        ld        = 1'b0;
        ld_byte   = 8'h00;
        mem_we    = 1'b0;
        rd_addr   = ptr;
        byte_done = (bit_cnt[2:0] == 3'd7);

        // CS high has priority over a coincident SCK edge.
        if (cs_hi) begin
            state_n   = S_IDLE;
            bit_cnt_n = 5'd0;
            miso_n    = 1'b0;
            oe_n      = 1'b0;
            wr_cmd_n  = 1'b0;
            if (wr_cmd) wel_n = 1'b0;
        end else if (state == S_IDLE) begin
            if (cs_fall) begin
                state_n   = S_OPCODE;
                bit_cnt_n = 5'd0;
            end
        end else if (sck_rise) begin
            shift_n   = sin[14:0];
            bit_cnt_n = bit_cnt + 5'd1;
            case (state)
                S_OPCODE: if (byte_done) begin
                    bit_cnt_n = 5'd0;
                    case (sin[7:0])
                        OP_WREN:  begin wel_n = 1'b1; state_n = S_IGNORE; end
                        OP_WRDI:  begin wel_n = 1'b0; state_n = S_IGNORE; end
                        OP_RDSR:  begin state_n = S_STATUS; ld = 1'b1; ld_byte = status_byte(wel); end
                        OP_READ:  state_n = S_ADDR;
                        OP_WRITE: begin state_n = S_ADDR; wr_cmd_n = 1'b1; end
                        default:  state_n = S_IGNORE;
                    endcase
                end
                S_ADDR: if (bit_cnt == 5'd15) begin
                    bit_cnt_n = 5'd0;
                    ptr_n     = sin[ADDR_W-1:0];
                    if (wr_cmd) begin
                        state_n = S_WDATA;
                    end else begin
                        state_n = S_RDATA;
                        rd_addr = sin[ADDR_W-1:0];
                        ld      = 1'b1;
                        ld_byte = mem[rd_addr];
                        ptr_n   = rd_addr + ADDR_W'(1);
                    end
                end
                S_WDATA: if (byte_done) begin
                    bit_cnt_n = 5'd0;
                    if (wel) begin
                        mem_we = 1'b1;
                        ptr_n  = ptr + ADDR_W'(1);
                    end
                end
                S_RDATA: if (byte_done) begin
                    bit_cnt_n = 5'd0;
                    ld        = 1'b1;
                    ld_byte   = mem[ptr];
                    ptr_n     = ptr + ADDR_W'(1);
                end
                S_STATUS: if (byte_done) begin
                    bit_cnt_n = 5'd0;
                    ld        = 1'b1;
                    ld_byte   = status_byte(wel);
                end
                default: ;
            endcase
        end else if (sck_fall && spi_miso_oe) begin
            // First fall after a load re-presents bit 7; later falls walk down the byte.
            miso_n = tx[3'd7 - bit_cnt[2:0]];
        end

        if (ld) begin
            tx_n   = ld_byte;
            miso_n = ld_byte[7];
            oe_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= 5'd0;
            shift_in    <= 15'd0;
            ptr         <= '0;
            wel         <= 1'b0;
            wr_cmd      <= 1'b0;
            tx          <= 8'h00;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            armed       <= 1'b0;
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift_in    <= shift_n;
            ptr         <= ptr_n;
            wel         <= wel_n;
            wr_cmd      <= wr_cmd_n;
            tx          <= tx_n;
            spi_miso    <= miso_n;
            spi_miso_oe <= oe_n;
            if (cs_hi) armed <= 1'b1;
            if (mem_we) mem[ptr] <= sin[7:0];
        end
    end

endmodule

// File: tb/tb_fram_spi_target.sv
// Directed bench for fram_spi_target: acts as a mode-0 SPI master with SCK at clk/10.
module tb_fram_spi_target;
    import fram_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, wel, cs_active;
    logic [7:0]  bd_addr = 8'h00;
    logic [7:0]  bd_data;
    fram_state_e state_dbg;

    int checks = 0;
    int errors = 0;

    fram_spi_target #(.MEM_BYTES(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wel(wel), .cs_active(cs_active), .bd_addr(bd_addr), .bd_data(bd_data),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                            output logic oe_all, output logic oe_any);
        rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (5) @(negedge clk);
            rx     = {rx[6:0], spi_miso};
            oe_all = oe_all & spi_miso_oe;
            oe_any = oe_any | spi_miso_oe;
            spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx; logic a, b;
        spi_xfer(tx, 8, rx, a, b);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (6) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_mem(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        bd_addr = addr;
        #1;
        check(tag, bd_data, exp);
    endtask

    logic [7:0] rx;
    logic       oe_all, oe_any;
    int         nonzero;

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // reset state
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_wel", wel, 1'b0);
        check("rst_cs_active", cs_active, 1'b0);
        check("rst_state", state_dbg, S_IDLE);
        check_mem("rst_mem10", 8'h10, 8'h00);

        // WREN then WRITE 0x0010 DE AD BE EF
        cs_begin();
        check("cs_active_low", cs_active, 1'b1);
        send(OP_WREN);
        cs_end();
        check("wel_after_wren", wel, 1'b1);
        cs_begin();
        send(OP_WRITE); send(8'h00); send(8'h10);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        cs_end();
        check_mem("wr_mem10", 8'h10, 8'hDE);
        check_mem("wr_mem11", 8'h11, 8'hAD);
        check_mem("wr_mem12", 8'h12, 8'hBE);
        check_mem("wr_mem13", 8'h13, 8'hEF);
        check("wel_cleared_by_write", wel, 1'b0);

        // WRITE without WREN is dropped
        cs_begin();
        send(OP_WRITE); send(8'h00); send(8'h20); send(8'h55);
        cs_end();
        check_mem("nowel_mem20", 8'h20, 8'h00);
        check("nowel_wel", wel, 1'b0);

        // READ 0x0010, 4 data bytes
        cs_begin();
        spi_xfer(OP_READ, 8, rx, oe_all, oe_any);
        check("rd_oe_opcode", oe_any, 1'b0);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        spi_xfer(8'h10, 8, rx, oe_all, oe_any);
        check("rd_oe_addr", oe_any, 1'b0);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("rd_byte0", rx, 8'hDE);
        check("rd_oe_data", oe_all, 1'b1);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("rd_byte1", rx, 8'hAD);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("rd_byte2", rx, 8'hBE);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("rd_byte3", rx, 8'hEF);
        cs_end();
        check("rd_oe_after_cs", spi_miso_oe, 1'b0);
        check("rd_miso_after_cs", spi_miso, 1'b0);

        // WRDI clears WEL on the opcode
        cs_begin(); send(OP_WREN); cs_end();
        cs_begin(); send(OP_WRDI); cs_end();
        check("wel_after_wrdi", wel, 1'b0);

        // address wrap on write, upper address bits ignored on read
        cs_begin(); send(OP_WREN); cs_end();
        cs_begin();
        send(OP_WRITE); send(8'h00); send(8'hFF); send(8'h11); send(8'h22);
        cs_end();
        check_mem("wrap_memff", 8'hFF, 8'h11);
        check_mem("wrap_mem00", 8'h00, 8'h22);
        cs_begin();
        send(OP_READ); send(8'h01); send(8'hFF);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("wrap_rd_ff", rx, 8'h11);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("wrap_rd_00", rx, 8'h22);
        cs_end();

        // partial data byte is discarded; WEL still clears
        cs_begin(); send(OP_WREN); cs_end();
        cs_begin();
        send(OP_WRITE); send(8'h00); send(8'h30);
        spi_xfer(8'hAA, 5, rx, oe_all, oe_any);
        cs_end();
        check_mem("partial_mem30", 8'h30, 8'h00);
        cs_begin();
        send(OP_RDSR);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("rdsr_wel0", rx, 8'h00);
        cs_end();
        cs_begin(); send(OP_WREN); cs_end();
        cs_begin();
        send(OP_RDSR);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("rdsr_wel1", rx, 8'h02);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("rdsr_repeat", rx, 8'h02);
        cs_end();

        // unknown opcode is ignored, no drive
        cs_begin();
        spi_xfer(8'h9F, 8, rx, oe_all, oe_any);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("unknown_op_oe", oe_any, 1'b0);
        cs_end();

        // reset in the middle of a READ
        cs_begin();
        send(OP_READ); send(8'h00); send(8'h10);
        spi_xfer(8'h00, 3, rx, oe_all, oe_any);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_miso", spi_miso, 1'b0);
        check("midrst_oe", spi_miso_oe, 1'b0);
        check("midrst_wel", wel, 1'b0);
        check("midrst_state", state_dbg, S_IDLE);
        nonzero = 0;
        for (int a = 0; a < 256; a++) begin
            bd_addr = 8'(a);
            #1;
            if (bd_data !== 8'h00) nonzero++;
        end
        check("midrst_mem_nonzero_count", nonzero, 0);
        spi_xfer(8'hFF, 8, rx, oe_all, oe_any);
        check("midrst_stay_idle", state_dbg, S_IDLE);
        check("midrst_no_drive", oe_any, 1'b0);
        cs_end();

        // fresh transactions after reset
        cs_begin(); send(OP_WREN); cs_end();
        check("post_rst_wel", wel, 1'b1);
        cs_begin();
        send(OP_WRITE); send(8'h00); send(8'h05); send(8'h3C);
        cs_end();
        check_mem("post_rst_mem05", 8'h05, 8'h3C);
        cs_begin();
        send(OP_READ); send(8'h00); send(8'h05);
        spi_xfer(8'h00, 8, rx, oe_all, oe_any);
        check("post_rst_rd05", rx, 8'h3C);
        cs_end();

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
